multicycle_controller: RTL and testbench

//  FSM sequencer that runs the RV32I datapath (pc, registerfile, alu) as a multicycle machine over one shared memory port.

---
 rtl/multicycle_controller.sv | 183 ++++++++++++++++++
 tb/tb_multicycle_controller.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// Multicycle RV32I sequencer: fetch/decode/exec/mem/wb FSM over one shared memory port.
// Optional perf counters are built when PERF_COUNTER_EN is defined; otherwise they read 0.
module multicycle_controller #(
  parameter int CNT_W = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [31:0]      inst,
  input  logic             branch_cond,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_wr,
  output logic             addr_sel,
  output logic             ir_wr,
  output logic             pc_wr,
  output logic             pc_src,
  output logic             reg_wr,
  output logic [1:0]       wb_sel,
  output logic             alu_src_a,
  output logic             alu_src_b,
  output logic [3:0]       alu_op,
  output logic             halted,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);

  localparam logic [2:0] S_FETCH  = 3'b000;
  localparam logic [2:0] S_DECODE = 3'b001;
  localparam logic [2:0] S_EXEC   = 3'b010;
  localparam logic [2:0] S_MEM    = 3'b011;
  localparam logic [2:0] S_WB     = 3'b100;
  localparam logic [2:0] S_TRAP   = 3'b101;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  logic [2:0] state;
  logic [2:0] state_nxt;

  logic [6:0] opcode;
  logic [2:0] f3;
  logic       f7b;
  logic       is_r, is_i, is_load, is_store, is_br, is_jal, is_jalr, is_lui, is_auipc;
  logic       legal;
  logic       unused_inst_bits;

  assign opcode   = inst[6:0];
  assign f3       = inst[14:12];
  assign f7b      = inst[30];
  assign is_r     = (opcode == OP_R);
  assign is_i     = (opcode == OP_I);
  assign is_load  = (opcode == OP_LOAD);
  assign is_store = (opcode == OP_STORE);
  assign is_br    = (opcode == OP_BR);
  assign is_jal   = (opcode == OP_JAL);
  assign is_jalr  = (opcode == OP_JALR);
  assign is_lui   = (opcode == OP_LUI);
  assign is_auipc = (opcode == OP_AUIPC);
  assign legal    = is_r | is_i | is_load | is_store | is_br | is_jal | is_jalr | is_lui | is_auipc;
  assign unused_inst_bits = ^{inst[31], inst[29:15], inst[11:7]};

  logic       req_c, wr_c, as_c, irw_c, pcw_c, pcs_c, rw_c, sa_c, sb_c;
  logic [1:0] wbs_c;
  logic [3:0] op_c;

  always_comb begin
    state_nxt = state;
    req_c = 1'b0;
    wr_c  = 1'b0;
    as_c  = 1'b0;
    irw_c = 1'b0;
    pcw_c = 1'b0;
    pcs_c = 1'b0;
    rw_c  = 1'b0;
    wbs_c = 2'b00;
    sa_c  = 1'b0;
    sb_c  = 1'b0;
    op_c  = 4'b0000;
    case (state)
      S_FETCH: begin
        req_c = 1'b1;
        if (mem_ready) begin
          irw_c     = 1'b1;
          state_nxt = S_DECODE;
        end
      end
      S_DECODE: state_nxt = legal ? S_EXEC : S_TRAP;
      S_EXEC: begin
        if (is_r) begin
          op_c = {f7b, f3};
        end else if (is_i) begin
          // Only the shift-right-immediate encodings carry funct7[5] (SRLI vs SRAI)
          op_c = {(f3 == 3'b101) ? f7b : 1'b0, f3};
          sb_c = 1'b1;
        end else if (is_load | is_store | is_jalr | is_lui) begin
          sb_c = 1'b1;
        end else begin
          sa_c = 1'b1;
          sb_c = 1'b1;
        end
        if (is_load | is_store) begin
          state_nxt = S_MEM;
        end else if (is_br) begin
          pcw_c     = 1'b1;
          pcs_c     = branch_cond;
          state_nxt = S_FETCH;
        end else begin
          state_nxt = S_WB;
        end
      end
      S_MEM: begin
        req_c = 1'b1;
        as_c  = 1'b1;
        wr_c  = is_store;
        if (mem_ready) begin
          pcw_c     = is_store;
          state_nxt = is_store ? S_FETCH : S_WB;
        end
      end
      S_WB: begin
        rw_c      = 1'b1;
        wbs_c     = is_load ? 2'b01 : ((is_jal | is_jalr) ? 2'b10 : 2'b00);
        pcw_c     = 1'b1;
        pcs_c     = is_jal | is_jalr;
        state_nxt = S_FETCH;
      end
      S_TRAP:  state_nxt = S_TRAP;
      default: state_nxt = S_FETCH;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) state <= S_FETCH;
    else       state <= state_nxt;
  end

  // Outputs are forced low during the reset cycle, which also drops any held request
  assign mem_req   = ~reset & req_c;
  assign mem_wr    = ~reset & wr_c;
  assign addr_sel  = ~reset & as_c;
  assign ir_wr     = ~reset & irw_c;
  assign pc_wr     = ~reset & pcw_c;
  assign pc_src    = ~reset & pcs_c;
  assign reg_wr    = ~reset & rw_c;
  assign wb_sel    = reset ? 2'b00 : wbs_c;
  assign alu_src_a = ~reset & sa_c;
  assign alu_src_b = ~reset & sb_c;
  assign alu_op    = reset ? 4'b0000 : op_c;
  assign halted    = ~reset & (state == S_TRAP);

`ifdef PERF_COUNTER_EN
  logic             retire;
  logic [CNT_W-1:0] cyc_q;
  logic [CNT_W-1:0] ret_q;

  assign retire = (state == S_WB) | (state == S_EXEC & is_br) |
                  (state == S_MEM & is_store & mem_ready);

  always_ff @(posedge clock) begin
    if (reset) begin
      cyc_q <= '0;
      ret_q <= '0;
    end else if (state != S_TRAP) begin
      cyc_q <= cyc_q + CNT_W'(1);
      if (retire) ret_q <= ret_q + CNT_W'(1);
    end
  end

  assign cycle_cnt   = reset ? '0 : cyc_q;
  assign instret_cnt = reset ? '0 : ret_q;
`else
  assign cycle_cnt   = '0;
  assign instret_cnt = '0;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: per-instruction cycle schedules built from the ISA-level rules,
// compared every cycle against the DUT outputs and (when PERF_COUNTER_EN) its counters.
module tb_multicycle_controller;

  localparam int CNT_W = 32;
`ifdef PERF_COUNTER_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic             clock = 1'b0;
  logic             reset;
  logic [31:0]      inst;
  logic             branch_cond;
  logic             mem_ready;
  logic             mem_req, mem_wr, addr_sel, ir_wr, pc_wr, pc_src, reg_wr;
  logic [1:0]       wb_sel;
  logic             alu_src_a, alu_src_b, halted;
  logic [3:0]       alu_op;
  logic [CNT_W-1:0] cycle_cnt, instret_cnt;

  multicycle_controller #(.CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset), .inst(inst), .branch_cond(branch_cond),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_wr(mem_wr), .addr_sel(addr_sel),
    .ir_wr(ir_wr), .pc_wr(pc_wr), .pc_src(pc_src), .reg_wr(reg_wr), .wb_sel(wb_sel),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .halted(halted),
    .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
  );

  always #5 clock = ~clock;

  logic [15:0] dut_v;
  assign dut_v = {mem_req, mem_wr, addr_sel, ir_wr, pc_wr, pc_src, reg_wr, wb_sel,
                  alu_src_a, alu_src_b, alu_op, halted};

  int          cnt_checks = 0;
  int          cnt_errors = 0;
  int unsigned exp_cyc = 0;
  int unsigned exp_ret = 0;

  typedef struct packed {
    logic [15:0] v;
    logic        mr;
    logic        dc;
    logic        ret;
  } cyc_t;

  localparam int C_R = 0, C_I = 1, C_LD = 2, C_ST = 3, C_BR = 4,
                 C_JAL = 5, C_JALR = 6, C_LUI = 7, C_AUIPC = 8;

  function automatic logic [15:0] pk(input logic req, wr, as, irw, pcw, pcs, rw,
                                     input logic [1:0] wbs, input logic sa, sb,
                                     input logic [3:0] op, input logic h);
    return {req, wr, as, irw, pcw, pcs, rw, wbs, sa, sb, op, h};
  endfunction

  function automatic int cls_of(input logic [6:0] opc);
    case (opc)
      7'b0110011: return C_R;
      7'b0010011: return C_I;
      7'b0000011: return C_LD;
      7'b0100011: return C_ST;
      7'b1100011: return C_BR;
      7'b1101111: return C_JAL;
      7'b1100111: return C_JALR;
      7'b0110111: return C_LUI;
      7'b0010111: return C_AUIPC;
      default:    return -1;
    endcase
  endfunction

  function automatic logic [6:0] opc_of(input int c);
    case (c)
      C_R:     return 7'b0110011;
      C_I:     return 7'b0010011;
      C_LD:    return 7'b0000011;
      C_ST:    return 7'b0100011;
      C_BR:    return 7'b1100011;
      C_JAL:   return 7'b1101111;
      C_JALR:  return 7'b1100111;
      C_LUI:   return 7'b0110111;
      default: return 7'b0010111;
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] want_cyc();
    return PERF ? CNT_W'(exp_cyc) : '0;
  endfunction

  function automatic logic [CNT_W-1:0] want_ret();
    return PERF ? CNT_W'(exp_ret) : '0;
  endfunction

  // Runs one instruction: fw fetch waits, mw memory waits; abort_mem>=0 stops after that many MEM waits.
  task automatic run_inst(input logic [31:0] ins, input int fw, input int mw, input logic bc,
                          input int abort_mem, input string nm);
    cyc_t       q[$];
    int         c;
    logic [3:0] op;
    logic       sa, sb, st, lk;
    c  = cls_of(ins[6:0]);
    op = 4'b0000; sa = 1'b0; sb = 1'b0;
    st = (c == C_ST);
    lk = (c == C_JAL) || (c == C_JALR);
    for (int i = 0; i < fw; i++) q.push_back('{pk(1,0,0,0,0,0,0,2'b00,0,0,4'b0,0), 1'b0, 1'b0, 1'b0});
    q.push_back('{pk(1,0,0,1,0,0,0,2'b00,0,0,4'b0,0), 1'b1, 1'b0, 1'b0});
    q.push_back('{16'h0000, 1'b0, 1'b1, 1'b0});
    if (c >= 0) begin
      case (c)
        C_R:  op = {ins[30], ins[14:12]};
        C_I:  begin op = {(ins[14:12] == 3'b101) & ins[30], ins[14:12]}; sb = 1'b1; end
        C_LD, C_ST, C_JALR, C_LUI: sb = 1'b1;
        default: begin sa = 1'b1; sb = 1'b1; end
      endcase
      if (c == C_BR)
        q.push_back('{pk(0,0,0,0,1,bc,0,2'b00,sa,sb,op,0), 1'b0, 1'b1, 1'b1});
      else
        q.push_back('{pk(0,0,0,0,0,0,0,2'b00,sa,sb,op,0), 1'b0, 1'b1, 1'b0});
      if (c == C_LD || c == C_ST) begin
        for (int i = 0; i < ((abort_mem >= 0) ? abort_mem : mw); i++)
          q.push_back('{pk(1,st,1,0,0,0,0,2'b00,0,0,4'b0,0), 1'b0, 1'b0, 1'b0});
        if (abort_mem < 0)
          q.push_back('{pk(1,st,1,0,st,0,0,2'b00,0,0,4'b0,0), 1'b1, 1'b0, st});
      end
      if (c != C_BR && c != C_ST && abort_mem < 0)
        q.push_back('{pk(0,0,0,0,1,lk,1,(c == C_LD) ? 2'b01 : (lk ? 2'b10 : 2'b00),0,0,4'b0,0),
                      1'b0, 1'b1, 1'b1});
    end
    foreach (q[i]) begin
      inst        = ins;
      branch_cond = bc;
      mem_ready   = q[i].dc ? 1'($urandom_range(0, 1)) : q[i].mr;
      @(negedge clock);
      cnt_checks++;
      if (dut_v !== q[i].v) begin
        cnt_errors++;
        $display("FAIL %s step%0d outputs got %h want %h", nm, i, dut_v, q[i].v);
      end
      cnt_checks++;
      if ({cycle_cnt, instret_cnt} !== {want_cyc(), want_ret()}) begin
        cnt_errors++;
        $display("FAIL %s step%0d counters got %0d/%0d want %0d/%0d", nm, i,
                 cycle_cnt, instret_cnt, want_cyc(), want_ret());
      end
      @(posedge clock); #1;
      exp_cyc++;
      if (q[i].ret) exp_ret++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      mem_ready   = 1'($urandom_range(0, 1));
      branch_cond = 1'($urandom_range(0, 1));
      inst        = $urandom();
      @(negedge clock);
      cnt_checks++;
      if (dut_v !== 16'h0000 || cycle_cnt !== '0 || instret_cnt !== '0) begin
        cnt_errors++;
        $display("FAIL reset outputs got %h cnt %0d/%0d want 0000 cnt 0/0", dut_v, cycle_cnt, instret_cnt);
      end
      @(posedge clock); #1;
    end
    reset   = 1'b0;
    exp_cyc = 0;
    exp_ret = 0;
  endtask

  task automatic test_add();
    run_inst(32'h002081B3, 0, 0, 1'b0, -1, "add");
    run_inst(32'h002081B3, 2, 0, 1'b1, -1, "add_fetch_wait");
  endtask

  task automatic test_alu_ops();
    run_inst(32'h40208133, 0, 0, 1'b0, -1, "sub");
    run_inst(32'h4020D093, 0, 0, 1'b0, -1, "srai");
    run_inst(32'h4020C093, 0, 0, 1'b0, -1, "xori_f7set");
  endtask

  task automatic test_load_wait();
    run_inst(32'h0040A103, 0, 2, 1'b0, -1, "lw_wait2");
    run_inst(32'h0020A223, 1, 1, 1'b0, -1, "sw_wait1");
  endtask

  task automatic test_branch();
    run_inst(32'h00208463, 0, 0, 1'b1, -1, "beq_taken");
    run_inst(32'h00208463, 0, 0, 1'b0, -1, "beq_not_taken");
  endtask

  task automatic test_random();
    logic [31:0] r;
    for (int n = 0; n < 60; n++) begin
      r = $urandom();
      run_inst({r[31:7], opc_of($urandom_range(0, 8))}, $urandom_range(0, 2), $urandom_range(0, 3),
               1'($urandom_range(0, 1)), -1, "random");
    end
  endtask

  task automatic test_reset_mid_mem();
    run_inst(32'h0040A103, 0, 5, 1'b0, 2, "lw_abort");
    reset     = 1'b1;
    mem_ready = 1'b1;
    @(negedge clock);
    cnt_checks++;
    if (dut_v !== 16'h0000 || cycle_cnt !== '0 || instret_cnt !== '0) begin
      cnt_errors++;
      $display("FAIL reset_mid_mem outputs got %h cnt %0d/%0d want 0000 cnt 0/0", dut_v, cycle_cnt, instret_cnt);
    end
    @(posedge clock); #1;
    reset     = 1'b0;
    exp_cyc   = 0;
    exp_ret   = 0;
    mem_ready = 1'b0;
    @(negedge clock);
    cnt_checks++;
    if (dut_v !== pk(1,0,0,0,0,0,0,2'b00,0,0,4'b0,0) || cycle_cnt !== '0 || instret_cnt !== '0) begin
      cnt_errors++;
      $display("FAIL after_reset_fetch outputs got %h cnt %0d/%0d want %h cnt 0/0",
               dut_v, cycle_cnt, instret_cnt, pk(1,0,0,0,0,0,0,2'b00,0,0,4'b0,0));
    end
    @(posedge clock); #1;
    exp_cyc++;
    run_inst(32'h002081B3, 0, 0, 1'b0, -1, "add_after_abort");
  endtask

  task automatic test_trap();
    run_inst(32'h00000000, 0, 0, 1'b0, -1, "illegal");
    for (int i = 0; i < 6; i++) begin
      mem_ready   = 1'($urandom_range(0, 1));
      branch_cond = 1'($urandom_range(0, 1));
      inst        = $urandom();
      @(negedge clock);
      cnt_checks++;
      if (dut_v !== 16'h0001 || cycle_cnt !== want_cyc() || instret_cnt !== want_ret()) begin
        cnt_errors++;
        $display("FAIL trap cyc%0d outputs got %h cnt %0d/%0d want 0001 cnt %0d/%0d",
                 i, dut_v, cycle_cnt, instret_cnt, want_cyc(), want_ret());
      end
      @(posedge clock); #1;
    end
  endtask

  initial begin
    reset       = 1'b1;
    inst        = 32'h0;
    branch_cond = 1'b0;
    mem_ready   = 1'b0;
    @(posedge clock); #1;
    test_reset();
    test_add();
    test_alu_ops();
    test_load_wait();
    test_branch();
    test_random();
    test_reset_mid_mem();
    test_trap();
    test_reset();
    run_inst(32'h002081B3, 0, 0, 1'b0, -1, "add_after_trap");
    $display("CHECKS %0d ERRORS %0d", cnt_checks, cnt_errors);
    $finish;
  end

endmodule
